// File: rtl/player_move_arbiter_if.sv
// Paddle control bus: frame/button/camera inputs toward the arbiter, paddle
// position and status back toward the renderer and collision logic.
interface player_move_arbiter_if;
  logic       frame_tick;
  logic       left_button;
  logic       right_button;
  logic       cam_enable;
  logic       cam_valid;
  logic [9:0] cam_x;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       src_cam;
  logic       moving;

  modport master (
    output frame_tick, left_button, right_button, cam_enable, cam_valid, cam_x,
    input  player_x, player_y, src_cam, moving
  );

  modport slave (
    input  frame_tick, left_button, right_button, cam_enable, cam_valid, cam_x,
    output player_x, player_y, src_cam, moving
  );
endinterface

// File: rtl/player_move_arbiter.sv
// Paddle position owner: picks buttons or camera tracker as movement source
// and applies at most one bounded x step per frame_tick.
module player_move_arbiter #(
  parameter int PLAYER_SIZE_X = 32,
  parameter int PLAYER_SIZE_Y = 16,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int BOTTOM_MARGIN = 4,
  parameter int STEP          = 4,
  parameter int DEADBAND      = 2,
  parameter int CAM_TIMEOUT   = 30
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  player_move_arbiter_if.slave bus
);
  localparam int START_X = SCREEN_W/2 - PLAYER_SIZE_X/2;
  localparam int START_Y = SCREEN_H - BOTTOM_MARGIN - PLAYER_SIZE_Y;
  localparam int MAX_X   = SCREEN_W - PLAYER_SIZE_X;
  localparam int SW      = $clog2(CAM_TIMEOUT + 1);

  localparam logic [9:0]         MAX_X10 = 10'(MAX_X);
  localparam logic [9:0]         STEP10  = 10'(STEP);
  localparam logic signed [10:0] HALF_S  = 11'(PLAYER_SIZE_X/2);
  localparam logic signed [10:0] MAX_S   = 11'(MAX_X);
  localparam logic [10:0]        STEP11  = 11'(STEP);
  localparam logic [10:0]        DEAD11  = 11'(DEADBAND);

  typedef enum logic {BTN, CAM} state_t;
  state_t state, state_nxt;

  logic [1:0]         lsync, rsync;
  logic [9:0]         x, x_nxt, target;
  logic [SW-1:0]      stale_cnt;
  logic               mov;
  logic               left_p, right_p;
  logic signed [10:0] tgt_off, desired, err;
  logic [10:0]        abs_err;

  assign left_p  = ~lsync[1];
  assign right_p = ~rsync[1];

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lsync <= 2'b11;
      rsync <= 2'b11;
    end else begin
      lsync <= {lsync[0], bus.left_button};
      rsync <= {rsync[0], bus.right_button};
    end
  end

  // A fresh strobe wins over the staleness increment in the same cycle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      target    <= 10'(SCREEN_W/2);
      stale_cnt <= '0;
    end else if (bus.cam_valid) begin
      target    <= bus.cam_x;
      stale_cnt <= '0;
    end else if (bus.frame_tick && stale_cnt != SW'(CAM_TIMEOUT)) begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= BTN;
      x     <= 10'(START_X);
      mov   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.frame_tick) begin
        x   <= x_nxt;
        mov <= (x_nxt != x);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BTN: if (bus.cam_enable && bus.cam_valid) state_nxt = CAM;
      CAM: if (!bus.cam_enable || stale_cnt == SW'(CAM_TIMEOUT)) state_nxt = BTN;
      default: state_nxt = BTN;
    endcase
  end

  // Camera target is a centre; convert to a left edge clamped on screen.
  always_comb begin
    tgt_off = signed'({1'b0, target}) - HALF_S;
    desired = tgt_off;
    if (tgt_off < 11'sd0)  desired = 11'sd0;
    else if (tgt_off > MAX_S) desired = MAX_S;
    err     = desired - signed'({1'b0, x});
    abs_err = err[10] ? -err : err;
  end

  always_comb begin
    x_nxt = x;
    if (state == CAM) begin
      if (abs_err > STEP11)      x_nxt = err[10] ? x - STEP10 : x + STEP10;
      else if (abs_err > DEAD11) x_nxt = desired[9:0];
    end else if (left_p && !right_p) begin
      x_nxt = (x < STEP10) ? 10'd0 : x - STEP10;
    end else if (right_p && !left_p) begin
      x_nxt = (x > MAX_X10 - STEP10) ? MAX_X10 : x + STEP10;
    end
  end

  assign bus.player_x = x;
  assign bus.player_y = 10'(START_Y);
  assign bus.src_cam  = (state == CAM);
  assign bus.moving   = mov;
endmodule

// File: tb/tb_player_move_arbiter.sv
// Directed plus randomized bench for player_move_arbiter against a
// cycle-level behavioural model of the paddle rules.
module tb_player_move_arbiter;
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  player_move_arbiter_if bus();
  player_move_arbiter dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));

  int checks = 0, failures = 0;
  int m_x, m_tgt, m_stale, m_moving, m_cam;
  int lh[2], rh[2];   // button history seen by the paddle logic

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_x = 304; m_tgt = 320; m_stale = 0; m_moving = 0; m_cam = 0;
    lh = '{1, 1}; rh = '{1, 1};
  endtask

  task automatic model_step();
    int nx, d, e;
    bit lp, rp;
    nx = m_x;
    lp = (lh[1] == 0);
    rp = (rh[1] == 0);
    if (bus.frame_tick) begin
      if (m_cam != 0) begin
        d = m_tgt - 16;
        if (d < 0) d = 0;
        if (d > 608) d = 608;
        e = d - m_x;
        if (e > 4)                nx = m_x + 4;
        else if (e < -4)          nx = m_x - 4;
        else if (e > 2 || e < -2) nx = d;
      end else if (lp && !rp) nx = (m_x < 4) ? 0 : m_x - 4;
      else if (rp && !lp)     nx = (m_x > 604) ? 608 : m_x + 4;
      m_moving = (nx != m_x) ? 1 : 0;
    end
    if (m_cam != 0) begin
      if (!bus.cam_enable || m_stale == 30) m_cam = 0;
    end else if (bus.cam_enable && bus.cam_valid) m_cam = 1;
    if (bus.cam_valid) begin
      m_tgt = int'(bus.cam_x); m_stale = 0;
    end else if (bus.frame_tick && m_stale < 30) m_stale++;
    m_x = nx;
    lh[1] = lh[0]; lh[0] = int'(bus.left_button);
    rh[1] = rh[0]; rh[0] = int'(bus.right_button);
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    model_step();
    #1;
    chk("x",      int'(bus.player_x), m_x);
    chk("src",    int'(bus.src_cam),  m_cam);
    chk("moving", int'(bus.moving),   m_moving);
    chk("y",      int'(bus.player_y), 460);
    chk("bound",  int'(bus.player_x <= 10'd608), 1);
  endtask

  task automatic cycles(input int n, input bit tick);
    bus.frame_tick = tick;
    for (int i = 0; i < n; i++) cyc();
    bus.frame_tick = 1'b0;
  endtask

  task automatic cam_pulse(input int cx, input bit tick);
    bus.cam_valid = 1'b1; bus.cam_x = 10'(cx); bus.frame_tick = tick;
    cyc();
    bus.cam_valid = 1'b0; bus.frame_tick = 1'b0;
  endtask

  // Asynchronous assert between edges; outputs must drop at once.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    m_reset();
    chk("rst_x",   int'(bus.player_x), 304);
    chk("rst_y",   int'(bus.player_y), 460);
    chk("rst_src", int'(bus.src_cam),  0);
    chk("rst_mov", int'(bus.moving),   0);
    @(negedge CLOCK_50);
    reset = 1'b1;
  endtask

  initial begin
    bus.frame_tick = 0; bus.left_button = 1; bus.right_button = 1;
    bus.cam_enable = 0; bus.cam_valid = 0; bus.cam_x = '0;
    m_reset();
    #25;
    apply_reset();

    // idle ticks
    cycles(5, 1'b1);
    chk("idle_x", int'(bus.player_x), 304);

    // left to the wall, then right to the wall
    bus.left_button = 0;
    cycles(2, 1'b0);
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (i == 75) chk("left_t76", int'(bus.player_x), 0);
    end
    bus.frame_tick = 1'b0;
    chk("left_wall_mov", int'(bus.moving), 0);
    bus.left_button = 1; bus.right_button = 0;
    cycles(2, 1'b0);
    cycles(160, 1'b1);
    chk("right_wall", int'(bus.player_x), 608);
    bus.left_button = 0;
    cycles(2, 1'b0);
    cycles(3, 1'b1);
    chk("both_x", int'(bus.player_x), 608);
    chk("both_mov", int'(bus.moving), 0);
    bus.left_button = 1; bus.right_button = 1;
    cycles(2, 1'b0);

    // camera tracking, deadband, small jump
    #5 apply_reset();
    bus.cam_enable = 1;
    cam_pulse(336, 1'b0);
    chk("cam_src", int'(bus.src_cam), 1);
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("cam_step", int'(bus.player_x), 308 + 4*i);
    end
    bus.frame_tick = 1'b0;
    cycles(2, 1'b1);
    chk("cam_hold", int'(bus.player_x), 320);
    cam_pulse(338, 1'b0);
    cycles(2, 1'b1);
    chk("cam_dead", int'(bus.player_x), 320);
    cam_pulse(339, 1'b0);
    cycles(1, 1'b1);
    chk("cam_snap", int'(bus.player_x), 323);

    // staleness fallback, then buttons again
    cycles(30, 1'b1);
    cycles(1, 1'b0);
    chk("stale_src", int'(bus.src_cam), 0);
    bus.left_button = 0;
    cycles(2, 1'b0);
    cycles(3, 1'b1);
    chk("fallback_x", int'(bus.player_x), 311);
    bus.left_button = 1;
    cycles(2, 1'b0);
    cam_pulse(320, 1'b0);
    chk("reacq_src", int'(bus.src_cam), 1);
    bus.cam_enable = 0;
    cycles(1, 1'b0);
    chk("disable_src", int'(bus.src_cam), 0);

    // simultaneous tick and strobe uses old target
    bus.cam_enable = 1;
    cam_pulse(320, 1'b0);
    cycles(3, 1'b1);
    cam_pulse(600, 1'b1);
    cycles(5, 1'b1);
    #3 apply_reset();

    // randomized phase
    for (int blk = 0; blk < 8; blk++) begin
      int vprob;
      vprob = (blk % 2 == 0) ? 4 : 150;
      for (int i = 0; i < 500; i++) begin
        bus.frame_tick = ($urandom_range(0, 2) == 0);
        bus.cam_valid  = ($urandom_range(0, vprob - 1) == 0);
        bus.cam_x      = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 99) == 0) bus.cam_enable   = ~bus.cam_enable;
        if ($urandom_range(0, 29) == 0) bus.left_button  = ~bus.left_button;
        if ($urandom_range(0, 29) == 0) bus.right_button = ~bus.right_button;
        cyc();
        if ($urandom_range(0, 999) == 0) apply_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/player_move_arbiter.md
Name: player_move_arbiter

Overview:
- Owns the paddle position register (player_x, player_y) for the 640x480 game screen.
- Arbitrates between two movement sources:
  - board push-buttons (active-low);
  - the camera tracker, which supplies a target centre x.
- Applies at most one bounded step per frame_tick and falls back to buttons when camera data goes stale.
- Feeds the renderer and collision logic. Replaces direct button-to-position control.

Parameters:
- PLAYER_SIZE_X, 32, paddle width in pixels
- PLAYER_SIZE_Y, 16, paddle height in pixels
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- BOTTOM_MARGIN, 4, gap below paddle
- STEP, 4, maximum x change per frame_tick
- DEADBAND, 2, camera error (pixels) ignored
- CAM_TIMEOUT, 30, frame_ticks without cam_valid before falling back to buttons

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- frame_tick  in  1  one-cycle pulse per video frame
- left_button  in  1  asynchronous, active-low (0 = pressed)
- right_button  in  1  asynchronous, active-low (0 = pressed)
- cam_enable  in  1  camera source allowed
- cam_valid  in  1  one-cycle strobe; cam_x valid this cycle
- cam_x  in  10  camera target paddle centre x
- player_x  out  10  paddle left edge
- player_y  out  10  paddle top edge
- src_cam  out  1  1 = camera is the active source
- moving  out  1  1 = last frame_tick update changed player_x

Behaviour:
- Derived constants:
  - START_X = SCREEN_W/2 - PLAYER_SIZE_X/2 = 304
  - START_Y = SCREEN_H - BOTTOM_MARGIN - PLAYER_SIZE_Y = 460
  - MAX_X = SCREEN_W - PLAYER_SIZE_X = 608
- Reset (reset = 0, asynchronous):
  - player_x = 304, player_y = 460
  - state BTN, src_cam = 0, moving = 0
  - stale_cnt = 0, target = 320
  - button sync flops = 1
- Buttons: each passes through a 2-FF synchronizer. Pressed = synced value 0.
- Camera capture:
  - On cam_valid = 1: target <= cam_x and stale_cnt <= 0 (takes priority over increment).
  - Otherwise, on frame_tick: stale_cnt increments, saturating at CAM_TIMEOUT.
- FSM, states BTN and CAM; src_cam = (state == CAM):
  - BTN -> CAM when cam_enable = 1 and cam_valid = 1.
  - CAM -> BTN when cam_enable = 0 or stale_cnt == CAM_TIMEOUT.
  - The new state is effective on the next cycle.
- Movement happens only in cycles where frame_tick = 1 and uses the current (pre-transition) state and the pre-update target.
- BTN movement:
  - only left pressed: x <= (x < STEP) ? 0 : x - STEP
  - only right pressed: x <= (x > MAX_X - STEP) ? MAX_X : x + STEP
  - both or neither pressed: hold
- CAM movement:
  - desired = clamp(target - PLAYER_SIZE_X/2, 0, MAX_X), computed in 11-bit signed arithmetic; target < 16 gives 0, target > 624 gives 608.
  - err = desired - x
  - |err| <= DEADBAND: hold
  - DEADBAND < |err| <= STEP: x <= desired
  - |err| > STEP: x moves STEP toward desired
- player_x never leaves [0, MAX_X], under any input.
- moving: updated only on frame_tick, set to (new x != old x), held between ticks.
- player_y is constant START_Y after reset.
- Reset asserted mid-operation: all registers return to their reset values immediately; no partial step is completed.
- Latency:
  - button edge to position change: 2 sync cycles, then the next frame_tick
  - cam_valid to target usable: 1 cycle

Test Plan:
1. Reset release, no input, 5 frame_ticks -> player_x = 304, player_y = 460, src_cam = 0, moving = 0 throughout.
2. left_button held low from x = 304 for 80 ticks -> x decreases by 4 per tick; x reaches 0 at tick 76 and stays 0; moving = 0 after tick 77. right_button held from x = 600 -> 604, 608, then remains 608.
3. Both buttons held low for 3 ticks -> x unchanged, moving = 0.
4. cam_enable = 1, cam_valid with cam_x = 336, then ticks -> src_cam = 1 the cycle after the strobe; x goes 304 -> 308 -> 312 -> 316 -> 320, then holds. A later cam_x = 338 (desired 322, err 2) -> hold. A later cam_x = 339 (desired 323, err 3) -> x = 323.
5. In CAM, stop cam_valid -> after 30 frame_ticks src_cam = 0; a left press then moves x by -4 per tick. cam_enable dropped instead -> src_cam = 0 the next cycle.
6. frame_tick and cam_valid (cam_x = 600) in the same cycle while in CAM with target 320 -> that tick moves toward the old desired 304; the following ticks step +4 toward 584. Assert reset mid-sequence -> x = 304 and src_cam = 0 immediately.
